// File: rtl/one_wire_pkg.sv
// Shared 1-Wire definitions: command encodings, master FSM states and
// default slot timing for a 100 MHz clock.
package one_wire_pkg;

  typedef enum logic [1:0] {
    OW_OP_RESET = 2'd0,
    OW_OP_WRITE = 2'd1,
    OW_OP_READ  = 2'd2,
    OW_OP_NOP   = 2'd3
  } ow_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_LOW   = 3'd1,
    ST_RST_WAIT  = 3'd2,
    ST_SLOT_LOW  = 3'd3,
    ST_SLOT_HIGH = 3'd4,
    ST_SLOT_REC  = 3'd5,
    ST_DONE      = 3'd6
  } ow_state_e;

  localparam int OW_CNT_W       = 16;
  localparam int OW_T_RST_LOW   = 48000;
  localparam int OW_T_PRES_SAMP = 7000;
  localparam int OW_T_RST_TOTAL = 48000;
  localparam int OW_T_SLOT      = 6000;
  localparam int OW_T_W1_LOW    = 600;
  localparam int OW_T_W0_LOW    = 6000;
  localparam int OW_T_RD_LOW    = 100;
  localparam int OW_T_RD_SAMP   = 1300;
  localparam int OW_T_REC       = 100;

endpackage

// File: rtl/one_wire_master_ctrl_if.sv
// Command/result bundle between host logic (master) and the 1-Wire sequencer (slave).
// Valid/ready command handshake; results are level-held except the done pulse.
interface one_wire_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       done;
  logic       presence;
  logic [7:0] rd_data;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, done, presence, rd_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, done, presence, rd_data, busy
  );
endinterface

// File: rtl/one_wire_sync.sv
// Two-flop synchronizer for the raw 1-Wire line level; 2-cycle latency, no backpressure.
// Resets to the idle (released, high) line level so no false low is seen after reset.
module one_wire_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/one_wire_master_ctrl.sv
// 1-Wire bus master: sequences RESET, WRITE-byte and READ-byte with cycle-exact slot timing.
// One command in flight; cmd_ready only in IDLE while enabled, done pulses once per completed command.
module one_wire_master_ctrl
  import one_wire_pkg::*;
#(
  parameter int CNT_W       = OW_CNT_W,
  parameter int T_RST_LOW   = OW_T_RST_LOW,
  parameter int T_PRES_SAMP = OW_T_PRES_SAMP,
  parameter int T_RST_TOTAL = OW_T_RST_TOTAL,
  parameter int T_SLOT      = OW_T_SLOT,
  parameter int T_W1_LOW    = OW_T_W1_LOW,
  parameter int T_W0_LOW    = OW_T_W0_LOW,
  parameter int T_RD_LOW    = OW_T_RD_LOW,
  parameter int T_RD_SAMP   = OW_T_RD_SAMP,
  parameter int T_REC       = OW_T_REC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  ow_in,
  output logic                  ow_drive_low,
  one_wire_master_ctrl_if.slave cmd_if
);

  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(T_RST_LOW - 1);
  localparam logic [CNT_W-1:0] PRES_AT       = CNT_W'(T_PRES_SAMP);
  localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(T_RST_TOTAL - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN      = CNT_W'(T_SLOT);
  localparam logic [CNT_W-1:0] W1_LEN        = CNT_W'(T_W1_LOW);
  localparam logic [CNT_W-1:0] W0_LEN        = CNT_W'(T_W0_LOW);
  localparam logic [CNT_W-1:0] RD_LEN        = CNT_W'(T_RD_LOW);
  // The counter restarts in SLOT_HIGH, so the read sample point is offset by the low phase.
  localparam logic [CNT_W-1:0] RD_SAMP_AT    = CNT_W'(T_RD_SAMP - T_RD_LOW);
  localparam logic [CNT_W-1:0] REC_LAST      = CNT_W'(T_REC - 1);

  ow_state_e        state_q, state_d;
  ow_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, low_len, high_len;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             drive_q, drive_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             pres_smp_q, pres_smp_d;
  logic             presence_q, presence_d;
  logic             ow_sync, ready, accept;

  one_wire_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ow_in),
    .q    (ow_sync)
  );

  assign ready  = enable && (state_q == ST_IDLE);
  assign accept = cmd_if.cmd_valid && ready;

  always_comb begin
    low_len = data_q[bit_idx_q] ? W1_LEN : W0_LEN;
    if (op_q == OW_OP_READ) low_len = RD_LEN;
    high_len = SLOT_LEN - low_len;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_inc;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    drive_d    = drive_q;
    done_d     = 1'b0;
    pres_smp_d = pres_smp_q;
    presence_d = presence_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      drive_d   = 1'b0;
      bit_idx_d = 3'd7;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (accept) begin
            op_d      = ow_op_e'(cmd_if.cmd_op);
            data_d    = cmd_if.cmd_data;
            bit_idx_d = 3'd7;
            shift_d   = 8'h00;
            unique case (ow_op_e'(cmd_if.cmd_op))
              OW_OP_RESET: begin
                state_d = ST_RST_LOW;
                drive_d = 1'b1;
              end
              OW_OP_WRITE, OW_OP_READ: begin
                state_d = ST_SLOT_LOW;
                drive_d = 1'b1;
              end
              default: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            endcase
          end
        end
        ST_RST_LOW: begin
          if (cnt_q == RST_LOW_LAST) begin
            state_d = ST_RST_WAIT;
            drive_d = 1'b0;
          end
        end
        ST_RST_WAIT: begin
          if (cnt_q == PRES_AT) pres_smp_d = ~ow_sync;
          // presence is only published on completion so an aborted RESET leaves it untouched
          if (cnt_q == RST_WAIT_LAST) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            presence_d = pres_smp_d;
          end
        end
        ST_SLOT_LOW: begin
          if (cnt_q == low_len - CNT_ONE) begin
            drive_d = 1'b0;
            state_d = (high_len == '0) ? ST_SLOT_REC : ST_SLOT_HIGH;
          end
        end
        ST_SLOT_HIGH: begin
          if (op_q == OW_OP_READ && cnt_q == RD_SAMP_AT) shift_d = {shift_q[6:0], ow_sync};
          if (cnt_q == high_len - CNT_ONE) state_d = ST_SLOT_REC;
        end
        ST_SLOT_REC: begin
          if (cnt_q == REC_LAST) begin
            if (bit_idx_q == 3'd0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              if (op_q == OW_OP_READ) rd_data_d = shift_q;
            end else begin
              bit_idx_d = bit_idx_q - 3'd1;
              state_d   = ST_SLOT_LOW;
              drive_d   = 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OW_OP_NOP;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd7;
      data_q     <= 8'h00;
      shift_q    <= 8'h00;
      rd_data_q  <= 8'h00;
      drive_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      pres_smp_q <= 1'b0;
      presence_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      drive_q    <= drive_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pres_smp_q <= pres_smp_d;
      presence_q <= presence_d;
    end
  end

  assign ow_drive_low    = drive_q;
  assign cmd_if.cmd_ready = ready;
  assign cmd_if.done     = done_q;
  assign cmd_if.presence = presence_q;
  assign cmd_if.rd_data  = rd_data_q;
  assign cmd_if.busy     = busy_q;

endmodule

// File: doc/one_wire_master_ctrl.md
Name: one_wire_master_ctrl

Overview:
Bus-master sequencer for the 1-Wire link. Accepts RESET, WRITE-byte and READ-byte commands over a valid/ready handshake and generates the reset pulse and all time slots with cycle-accurate timing. Samples the presence pulse and read bits, and returns status and data. Sits between the host-side register/command logic and the open-drain pad shared with one_wire_rx-style responders. Bit order is MSB first, matching the receiver.

Parameters:
CNT_W, 16, width of the slot timing counter; must hold T_RST_LOW.
T_RST_LOW, 48000, reset low time in clk cycles (480 us at 100 MHz).
T_PRES_SAMP, 7000, cycles after reset release at which presence is sampled (70 us).
T_RST_TOTAL, 48000, cycles from reset release to end of the reset sequence.
T_SLOT, 6000, total slot length from falling edge, excluding recovery (60 us).
T_W1_LOW, 600, low time for a write-1 slot (6 us).
T_W0_LOW, 6000, low time for a write-0 slot (60 us).
T_RD_LOW, 100, low time for a read slot (1 us).
T_RD_SAMP, 1300, cycles after the falling edge at which a read bit is sampled (13 us).
T_REC, 100, released recovery gap after every slot (1 us).

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low aborts the current operation
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE with enable=1
cmd_op  in  2  0=RESET, 1=WRITE, 2=READ, 3=NOP
cmd_data  in  8  byte to write, MSB first
ow_in  in  1  raw line level from the pad
ow_drive_low  out  1  1 = pull line low, 0 = release (pad tristate)
done  out  1  one-cycle pulse when a command completes
presence  out  1  result of the last RESET; holds until the next RESET completes
rd_data  out  8  byte from the last READ; holds until the next READ completes
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: ow_drive_low=0, done=0, presence=0, rd_data=8'h00, busy=0, state=IDLE, counter=0, bit index=7.
- ow_in passes through a 2-FF synchronizer. All samples use the synchronized value, so they lag the line by 2 cycles, within spec margin.
- ow_drive_low is a registered output, glitch-free.
- Handshake: a command is accepted on a cycle where cmd_valid and cmd_ready are both high. cmd_op and cmd_data are latched then. cmd_valid while busy is ignored; no queueing.
- States: IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_HIGH, SLOT_REC, DONE.
- Accept RESET: go to RST_LOW, and ow_drive_low=1 from the next cycle for exactly T_RST_LOW cycles. Then go to RST_WAIT with the line released.
  - At count T_PRES_SAMP, latch presence = ~ow_in_sync.
  - At count T_RST_TOTAL, go to DONE.
- Accept WRITE or READ: bit index=7, go to SLOT_LOW, ow_drive_low=1 from the next cycle.
  - Low duration: T_W1_LOW if the data bit is 1, T_W0_LOW if 0, T_RD_LOW for READ.
  - Then SLOT_HIGH (released) until count T_SLOT from the falling edge. If the low time equals T_SLOT, SLOT_HIGH lasts 0 cycles.
  - Then SLOT_REC for T_REC cycles.
  - READ: at count T_RD_SAMP, shift ow_in_sync into the shift register LSB (MSB-first assembly).
  - After SLOT_REC: if bit index=0 go to DONE, else decrement the index and go to SLOT_LOW.
- Accept NOP: go directly to DONE with no line activity.
- DONE: done=1 for one cycle. rd_data is updated from the shift register in the same cycle for READ only. Return to IDLE.
- Command latency is set entirely by the parameters: 8 slots of (T_SLOT+T_REC) for byte ops, T_RST_LOW+T_RST_TOTAL for RESET, plus one accept cycle and one DONE cycle.
- enable deasserted in any state: next cycle goes to IDLE with ow_drive_low=0. No done is generated. presence and rd_data keep their old values. The partial read byte is discarded.
- rst_n asserted mid-operation: all outputs go to reset values immediately, and the line is released asynchronously.
- Counters saturate and never wrap. Each counter clears on every state entry.

Decomposition:
- Package one_wire_pkg holds:
  - the cmd_op encodings (OW_OP_RESET/WRITE/READ/NOP);
  - the state enumeration;
  - default timing constants at 100 MHz, shared with one_wire_rx and the benches.
- One natural sub-module: one_wire_sync, the 2-FF input synchronizer, reused by the receiver.

Test Plan:
- RESET with a BFM responder pulling the line low from 30 us to 150 us after release -> ow_drive_low low for 48000 cycles; done after 96000+2 cycles; presence=1.
- RESET with no responder (line pulled up) -> presence=0; done asserted; rd_data unchanged.
- WRITE 8'hA5 looped into a one_wire_rx instance -> low widths 600,6000,600,6000,6000,600,6000,600 cycles, each followed by a 100-cycle recovery; rx_byte=8'hA5; one done pulse.
- READ with the BFM holding the line low through sample point for bits of 8'h3C -> rd_data=8'h3C at done; eight 100-cycle low pulses observed.
- Drop enable during the 4th WRITE slot low phase -> ow_drive_low=0 next cycle; no done; cmd_ready returns once enable=1.
- Assert cmd_valid with a different command while busy -> it is ignored and cmd_ready stays 0. Re-presenting it after done is accepted normally. rst_n pulsed mid-RESET releases the line asynchronously.
